// File: rtl/ytydla_cmac_accu_tree.sv
// ytydla_cmac_accu_tree: pipelined 4-ary signed reduction tree with optional saturating multi-pass accumulator
//   ytydla_core_clk    clock
//   ytydla_core_rst_n  asynchronous active-low reset
//   in_valid/in_data   NUM_IN packed signed DATA_W operands, one vector per cycle
//   in_first/in_last   accumulation group delimiters (ACC_EN=1 only)
//   flush              synchronous clear of pipeline valids and accumulator
//   out_valid/out_data signed result saturated to OUT_W
//   out_sat            result or an intermediate accumulate was clamped
//   busy               some stage or the accumulator holds a live group
module ytydla_cmac_accu_tree #(
    parameter int DATA_W = 16,
    parameter int NUM_IN = 64,
    parameter int OUT_W  = 32,
    parameter bit ACC_EN = 1'b1
) (
    input  logic                     ytydla_core_clk,
    input  logic                     ytydla_core_rst_n,
    input  logic                     in_valid,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_sat,
    output logic                     busy
);
    localparam int L  = $clog2(NUM_IN) / 2;
    localparam int TW = DATA_W + 2 * L;
    localparam int AW = OUT_W + 8;
    localparam int SW = AW + 1;

    logic [L-1:0]  vld, fst, lst;
    logic [TW-1:0] tsum;

    // bit L-1 of each vector travels with the final tree level
    always_ff @(posedge ytydla_core_clk or negedge ytydla_core_rst_n) begin
        if (!ytydla_core_rst_n) begin
            vld <= '0;
            fst <= '0;
            lst <= '0;
        end else begin
            vld <= flush ? '0 : L'({vld, in_valid});
            fst <= L'({fst, in_first});
            lst <= L'({lst, in_last});
        end
    end

    for (genvar k = 0; k <= L; k++) begin : lvl
        localparam int N = NUM_IN >> (2 * k);
        localparam int W = DATA_W + 2 * k;
        logic [N*W-1:0] d;
        if (k == 0) begin : g
            assign d = in_data;
        end else begin : g
            localparam int PW = W - 2;
            logic [4*N*PW-1:0] p;
            logic [N*W-1:0]    s;
            assign p = lvl[k-1].d;
            always_comb begin
                s = '0;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < 4; j++)
                        s[i*W +: W] = s[i*W +: W] + W'($signed(p[(4*i+j)*PW +: PW]));
            end
            always_ff @(posedge ytydla_core_clk or negedge ytydla_core_rst_n) begin
                if (!ytydla_core_rst_n) d <= '0;
                else d <= s;
            end
        end
    end

    assign tsum = lvl[L].d;

    if (ACC_EN) begin : g_acc
        logic [AW-1:0] acc, nxt;
        logic [SW-1:0] sum;
        logic          grp_open, sticky, pend, ld, ovf, hi, lo;
        // a pass arriving with no open group starts one; overflowing accumulates pin to the AW range
        always_comb begin
            ld  = fst[L-1] | ~grp_open;
            sum = {acc[AW-1], acc} + SW'($signed(tsum));
            ovf = ~ld & (sum[AW] ^ sum[AW-1]);
            nxt = ld ? AW'($signed(tsum)) : ovf ? {sum[AW], {(AW-1){~sum[AW]}}} : sum[AW-1:0];
            hi  = $signed(acc) > $signed({9'b0, {(OUT_W-1){1'b1}}});
            lo  = $signed(acc) < $signed({9'h1ff, {(OUT_W-1){1'b0}}});
        end
        always_ff @(posedge ytydla_core_clk or negedge ytydla_core_rst_n) begin
            if (!ytydla_core_rst_n) begin
                acc       <= '0;
                grp_open  <= 1'b0;
                sticky    <= 1'b0;
                pend      <= 1'b0;
                out_valid <= 1'b0;
                out_data  <= '0;
                out_sat   <= 1'b0;
            end else if (flush) begin
                acc       <= '0;
                grp_open  <= 1'b0;
                sticky    <= 1'b0;
                pend      <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                if (vld[L-1]) begin
                    acc      <= nxt;
                    grp_open <= ~lst[L-1];
                    sticky   <= (sticky & ~ld) | ovf;
                end
                pend      <= vld[L-1] & lst[L-1];
                out_valid <= pend;
                if (pend) begin
                    out_data <= hi ? {1'b0, {(OUT_W-1){1'b1}}} : lo ? {1'b1, {(OUT_W-1){1'b0}}} : acc[OUT_W-1:0];
                    out_sat  <= sticky | hi | lo;
                end
            end
        end
        assign busy = |vld | grp_open | pend;
    end else begin : g_dir
        always_ff @(posedge ytydla_core_clk or negedge ytydla_core_rst_n) begin
            if (!ytydla_core_rst_n) begin
                out_valid <= 1'b0;
                out_data  <= '0;
            end else begin
                out_valid <= vld[L-1] & ~flush;
                out_data  <= OUT_W'($signed(tsum));
            end
        end
        assign out_sat = 1'b0;
        assign busy    = |vld;
    end
endmodule

// File: doc/ytydla_cmac_accu_tree.md
Name: ytydla_cmac_accu_tree

Overview:
Parametrised, pipelined reduction adder tree with valid handshake and an optional running accumulator. It sums NUM_IN signed partial products from the CMAC array into one result per cycle, replacing the fixed 64-input, three-level tree. It adds sign-extended width growth, a valid/flush pipeline, multi-pass accumulation across kernel slices, and output saturation. It sits between the CMAC multiplier array and the accumulator write-back path.

Parameters:
DATA_W, 16, width of each signed input operand
NUM_IN, 64, number of inputs; power of 4 from 4 to 256
OUT_W, 32, width of the signed output; must be at least DATA_W + log2(NUM_IN)
ACC_EN, 1, 1 = running accumulation across passes; 0 = each tree result emitted directly

Ports:
ytydla_core_clk  input  1  clock
ytydla_core_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data is valid this cycle
in_data  input  NUM_IN*DATA_W  packed signed operands; operand i at [i*DATA_W +: DATA_W]
in_first  input  1  first pass of an accumulation group (qualified by in_valid)
in_last  input  1  last pass of an accumulation group (qualified by in_valid)
flush  input  1  synchronous clear of pipeline valids and accumulator
out_valid  output  1  out_data is valid
out_data  output  OUT_W  signed result, saturated to OUT_W
out_sat  output  1  saturation occurred in the emitted group
busy  output  1  some pipeline stage or the accumulator holds a live group

Behaviour:
- Reset: ytydla_core_rst_n is asynchronous and active-low; ytydla_core_clk is the clock. On reset, all outputs, stage valids, the accumulator and the sticky saturation flag go to 0. Reset asserted mid-operation discards all in-flight data.
- Tree: L = log4(NUM_IN) levels of 4-input adders. Each level output is registered. Each level grows by 2 bits, so level k holds DATA_W+2k bits. Operands are sign-extended, so the tree has no overflow.
- Each stage carries valid, first and last bits alongside its data. There is no backpressure and the block accepts one input every cycle.
- ACC_EN=0: out_valid asserts exactly L+1 cycles after in_valid. out_data equals the tree sum sign-extended to OUT_W. in_first and in_last are ignored.
- ACC_EN=1: the accumulator register is OUT_W+8 bits wide.
  - On a tree-output valid with first=1, the accumulator loads the tree sum.
  - On a valid with first=0, the accumulator adds the tree sum to its current value.
  - On a valid with last=1, the final value is emitted on the next cycle, so latency from the last input is L+2. The accumulator value is then unused until the next first.
  - out_valid pulses only for the last pass.
  - first=1 and last=1 together form a single-pass group: load and emit.
- Saturation: on emit, a value above 2^(OUT_W-1)-1 is clamped to max and a value below -2^(OUT_W-1) is clamped to min. out_sat is set if the emitted value was clamped or if any intermediate accumulate exceeded the OUT_W+8 range. The sticky flag clears on first.
- A valid with first=0 arriving while no group is open is treated as first=1.
- flush: on the next edge, all stage valids and out_valid go to 0, and the accumulator and sticky flag clear. If in_valid is asserted in the same cycle as flush, that input is dropped.
- busy = OR of all stage valids, OR'd with the group-open flag when ACC_EN=1.
- Gaps in in_valid are allowed and do not disturb an open group.

Test Plan:
- NUM_IN=64, ACC_EN=0, all inputs 1 for one cycle -> out_valid exactly 4 cycles later with out_data=64, and a single pulse.
- NUM_IN=64, all inputs -32768 -> out_data=-2097152 with no saturation; all inputs 32767 -> 2097088.
- ACC_EN=1, 3 passes of all inputs = 2 (first on pass 0, last on pass 2) with an idle cycle between passes 1 and 2 -> one out_valid, out_data=384, latency L+2 from the last pass.
- ACC_EN=1, OUT_W=22, 2 passes of all inputs 32767 -> out_data=2097151, out_sat=1; the next group, of 1s, gives out_sat=0.
- Back-to-back first+last groups every cycle, values 1..10 per input -> 10 consecutive out_valid pulses, out_data = 64×k, in order.
- flush, then a reset pulse, each asserted while 3 tree stages are valid -> no out_valid, busy=0 the next cycle, and the next group's result is unaffected.
